ps2_rx: RTL and testbench
=========================

# ps2_rx

PS/2 keyboard receiver. Synchronises and filters the raw `ps2_clk`/`ps2_data` lines, deframes 11-bit device-to-host frames, and checks start, parity and stop bits. It keeps the last two good bytes as a 16-bit code word. It sits directly upstream of the 7-segment hex stage, driving its 16-bit data input and its error flag.

## Interface
- `FILTER_LEN`, default 8: consecutive equal samples of synchronised `ps2_clk` required before the filtered clock level changes; legal range 1–255.
- `TIMEOUT_CYCLES`, default 50000: `clk` cycles without a filtered falling edge, while inside a frame, after which the frame is aborted (1 ms at 50 MHz).
- `clk`  in  1  system clock; only clock in the block.
- `rst`  in  1  reset, synchronous, active-high.
- `ps2_clk`  in  1  raw PS/2 clock line, asynchronous to `clk`.
- `ps2_data`  in  1  raw PS/2 data line, asynchronous to `clk`.
- `code`  out  16  last two good bytes: `[15:8]` previous byte, `[7:0]` newest byte.
- `error`  out  1  sticky frame-error flag.
- `code_valid`  out  1  one-cycle pulse when `code` is updated.

## Operation
- **Input conditioning:**
  - Two-flop synchroniser on each PS/2 line.
  - Filter counter on synchronised `ps2_clk`: counts cycles where the sample differs from the filtered level and clears when they match. At `FILTER_LEN` the filtered level toggles.
  - Filtered level resets to 1.
  - Falling edge (filtered 1→0) produces a one-cycle internal `fall` strobe. Synchronised `ps2_data` is sampled in the `fall` cycle.
- **FSM states:** IDLE, DATA, PARITY, STOP. Reset state is IDLE.
  - **IDLE:** on `fall` with data=0 → DATA, bit count=0. On `fall` with data=1 → set `error`, stay in IDLE.
  - **DATA:** on each `fall`, shift the bit into the byte register LSB-first and increment a 3-bit count. After the 8th bit → PARITY.
  - **PARITY:** on `fall`, latch the bit → STOP. The frame is good when the 8 data bits plus parity contain an odd number of ones.
  - **STOP:** on `fall` → IDLE.
    - If stop=1 and parity is good: `code <= {code[7:0], byte}`, `code_valid`=1 for one cycle, `error`=0.
    - Otherwise: `error`=1, `code` unchanged, no `code_valid`.
- **Timeout:**
  - The counter clears on every `fall` and in IDLE; it counts only in DATA, PARITY and STOP.
  - When it reaches `TIMEOUT_CYCLES`: `error`=1, return to IDLE, discard the partial byte, leave `code` unchanged.
  - A timeout and a `fall` in the same cycle: the `fall` wins, the counter clears and the frame continues.
- **Error:** stays set until the next good frame completes or `rst`.
- **Multi-byte sequences** (E0 xx, F0 xx) need no special decode. The shift behaviour presents e.g. a break of A as `code`=16'hF01C.
- **Host-to-device** transmission is not supported; both lines are input only.

## Timing
- **Reset** (`rst`=1 at a `clk` edge):
  - Outputs: `code`=16'h0000, `error`=0, `code_valid`=0.
  - Internal: FSM=IDLE; synchroniser, filter and timeout counters cleared; filtered clock=1.
  - Reset mid-frame discards the frame silently, with no error.
- **Input latency:** raw `ps2_clk` fall to `fall` strobe is `FILTER_LEN`+3 `clk` cycles when the line is stable. Glitches shorter than `FILTER_LEN` cycles are ignored.
- **Output latency:** `code`, `error` and `code_valid` are registered and change in the cycle after the `fall` that samples the stop bit.
- **Minimum supported PS/2 clock half-period:** `FILTER_LEN`+4 `clk` cycles.
- **Back-to-back frames:** legal with no gap beyond the PS/2 protocol minimum. IDLE accepts the start bit on the very next `fall`.
- **Outputs** are glitch-free registers suitable to feed the combinational hex stage directly.

## Test plan
1. Reset, then frame byte 0x1C (data LSB-first 0,0,1,1,1,0,0,0; parity 0; stop 1) at 10 kHz with `clk` 50 MHz → one `code_valid` pulse, `code`=16'h001C, `error`=0.
2. Frames 0xF0 then 0x1C back-to-back → two pulses; `code`=16'h00F0 then 16'hF01C.
3. Frame 0x1C with parity forced to 1 → `error`=1, `code` unchanged, no pulse. Next good frame 0x32 → `error`=0, `code`=16'h1C32.
4. Start bit, then ps2_clk held high for 60000 cycles → `error`=1 at cycle 50000 after the last `fall`. FSM in IDLE, so a following good frame 0x1C decodes correctly.
5. 3-cycle low glitches injected on `ps2_clk` during a good 0x1C frame (`FILTER_LEN`=8) → glitches ignored, `code`=16'h001C, `error`=0.
6. `rst` asserted after 5 data bits of a frame, then released, then a good frame 0x45 → outputs reset to 0 with no error, then `code`=16'h0045.

Source files
------------

// File: rtl/ps2_rx_if.sv
// rtl/ps2_rx_if.sv - code word bus from the PS/2 receiver to the hex display stage
//
// Purpose: carries the decoded 16-bit code word, its update strobe and the
//          sticky frame-error flag.
// Signals:
//   code        16  last two good bytes, [15:8] previous, [7:0] newest
//   error        1  sticky frame-error flag
//   code_valid   1  one-cycle pulse when code is updated
// Modports: master drives the bus (receiver), slave consumes it (hex stage).
interface ps2_rx_if;
  logic [15:0] code;
  logic        error;
  logic        code_valid;

  modport master (output code, output error, output code_valid);
  modport slave  (input  code, input  error, input  code_valid);
endinterface

// File: rtl/ps2_rx.sv
// rtl/ps2_rx.sv - PS/2 device-to-host frame receiver with input filtering
//
// Purpose: synchronises and filters the raw PS/2 lines, deframes 11-bit
//          frames (start, 8 data LSB-first, odd parity, stop) and keeps the
//          last two good bytes as a 16-bit code word.
// Ports:
//   clk       in   system clock
//   rst       in   synchronous active-high reset
//   ps2_clk   in   raw PS/2 clock line (asynchronous)
//   ps2_data  in   raw PS/2 data line (asynchronous)
//   out_if    master modport: code[15:0], error, code_valid
module ps2_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      ps2_clk,
  input  logic      ps2_data,
  ps2_rx_if.master  out_if
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } state_t;

  // Input conditioning state.
  logic          clk_s1_q, clk_s2_q;
  logic          dat_s1_q, dat_s2_q;
  logic [7:0]    flt_cnt_q, flt_cnt_d;
  logic          filt_q, filt_d;
  logic          fall_q;

  // Frame state.
  state_t        state_q;
  logic [2:0]    bit_cnt_q;
  logic [7:0]    shift_q;
  logic          par_q;
  logic [TW-1:0] to_cnt_q;
  logic [15:0]   code_q;
  logic          error_q;
  logic          valid_q;

  // The filtered level only follows the synchronised clock after FILTER_LEN
  // consecutive disagreeing samples; any agreeing sample restarts the count.
  always_comb begin
    flt_cnt_d = 8'd0;
    filt_d    = filt_q;
    if (clk_s2_q != filt_q) begin
      if (flt_cnt_q == 8'(FILTER_LEN - 1)) begin
        filt_d = clk_s2_q;
      end else begin
        flt_cnt_d = flt_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_s1_q  <= 1'b1;
      clk_s2_q  <= 1'b1;
      dat_s1_q  <= 1'b1;
      dat_s2_q  <= 1'b1;
      flt_cnt_q <= 8'd0;
      filt_q    <= 1'b1;
      fall_q    <= 1'b0;
    end else begin
      clk_s1_q  <= ps2_clk;
      clk_s2_q  <= clk_s1_q;
      dat_s1_q  <= ps2_data;
      dat_s2_q  <= dat_s1_q;
      flt_cnt_q <= flt_cnt_d;
      filt_q    <= filt_d;
      fall_q    <= filt_q & ~filt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= 3'd0;
      shift_q   <= 8'd0;
      par_q     <= 1'b0;
      to_cnt_q  <= '0;
      code_q    <= 16'h0000;
      error_q   <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (fall_q) begin
        // A falling edge always wins over an expiring timeout.
        to_cnt_q <= '0;
        case (state_q)
          S_IDLE: begin
            if (!dat_s2_q) begin
              state_q   <= S_DATA;
              bit_cnt_q <= 3'd0;
            end else begin
              error_q <= 1'b1;
            end
          end
          S_DATA: begin
            shift_q   <= {dat_s2_q, shift_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) state_q <= S_PARITY;
          end
          S_PARITY: begin
            par_q   <= dat_s2_q;
            state_q <= S_STOP;
          end
          S_STOP: begin
            state_q <= S_IDLE;
            if (dat_s2_q && (^{shift_q, par_q})) begin
              code_q  <= {code_q[7:0], shift_q};
              valid_q <= 1'b1;
              error_q <= 1'b0;
            end else begin
              error_q <= 1'b1;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end else if (state_q == S_IDLE) begin
        to_cnt_q <= '0;
      end else if (to_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
        // Counter reaches TIMEOUT_CYCLES on this edge: abort the frame.
        to_cnt_q <= '0;
        state_q  <= S_IDLE;
        error_q  <= 1'b1;
      end else begin
        to_cnt_q <= to_cnt_q + TW'(1);
      end
    end
  end

  assign out_if.code       = code_q;
  assign out_if.error      = error_q;
  assign out_if.code_valid = valid_q;

endmodule

// File: tb/tb_ps2_rx.sv
// tb/tb_ps2_rx.sv - directed scoreboard bench for ps2_rx
module tb_ps2_rx;
  localparam int FL   = 8;
  localparam int TO   = 2000;
  localparam int HALF = 50;

  logic clk      = 1'b0;
  logic rst      = 1'b1;
  logic ps2_clk  = 1'b1;
  logic ps2_data = 1'b1;

  ps2_rx_if bus ();

  ps2_rx #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
    .clk      (clk),
    .rst      (rst),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .out_if   (bus)
  );

  always #10 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  int          pulses = 0;
  int          p0;
  logic [15:0] exp_q[$];
  logic [15:0] model_code = 16'h0000;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Scoreboard: every code_valid pulse must match the oldest pending entry.
  always @(negedge clk) begin
    if (bus.code_valid === 1'b1) begin
      pulses++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL unexpected_valid: observed=%h expected=none", bus.code);
      end else begin
        chk("code_on_valid", bus.code, exp_q.pop_front());
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b, input bit glitch);
    ps2_data = b;
    if (glitch) begin
      wait_cyc(20);
      ps2_clk = 1'b0;
      wait_cyc(3);
      ps2_clk = 1'b1;
      wait_cyc(HALF - 23);
    end else begin
      wait_cyc(HALF);
    end
    ps2_clk = 1'b0;
    wait_cyc(HALF);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit glitch);
    send_bit(1'b0, glitch);
    for (int i = 0; i < 8; i++) send_bit(b[i], glitch);
    send_bit((~^b) ^ bad_par, glitch);
    if (!bad_par) begin
      model_code = {model_code[7:0], b};
      exp_q.push_back(model_code);
    end
    send_bit(1'b1, glitch);
    ps2_data = 1'b1;
    wait_cyc(HALF);
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    wait_cyc(3);
    chk("rst_code", bus.code, 16'h0000);
    chk("rst_error", {15'b0, bus.error}, 16'h0000);
    chk("rst_valid", {15'b0, bus.code_valid}, 16'h0000);
    model_code = 16'h0000;
    exp_q.delete();
    rst = 1'b0;
    wait_cyc(2 * HALF);
  endtask

  initial begin
    // 1: single good frame
    do_reset();
    p0 = pulses;
    send_frame(8'h1C, 1'b0, 1'b0);
    chk("t1_code", bus.code, 16'h001C);
    chk("t1_error", {15'b0, bus.error}, 16'h0000);
    chk("t1_pulses", 16'(pulses - p0), 16'd1);

    // 2: back-to-back break sequence
    do_reset();
    p0 = pulses;
    send_frame(8'hF0, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b0);
    chk("t2_code", bus.code, 16'hF01C);
    chk("t2_pulses", 16'(pulses - p0), 16'd2);

    // 3: parity error, then recovery
    p0 = pulses;
    send_frame(8'h1C, 1'b1, 1'b0);
    chk("t3_err_set", {15'b0, bus.error}, 16'h0001);
    chk("t3_code_kept", bus.code, 16'hF01C);
    chk("t3_no_pulse", 16'(pulses - p0), 16'd0);
    send_frame(8'h32, 1'b0, 1'b0);
    chk("t3_err_clr", {15'b0, bus.error}, 16'h0000);
    chk("t3_code", bus.code, 16'h1C32);

    // 4: start bit then clock stalls high -> timeout
    p0 = pulses;
    ps2_data = 1'b0;
    wait_cyc(HALF);
    ps2_clk = 1'b0;
    wait_cyc(HALF);
    ps2_clk = 1'b1;
    wait_cyc(TO - 100);
    chk("t4_before_to", {15'b0, bus.error}, 16'h0000);
    wait_cyc(100);
    chk("t4_after_to", {15'b0, bus.error}, 16'h0001);
    ps2_data = 1'b1;
    wait_cyc(400);
    chk("t4_code_kept", bus.code, 16'h1C32);
    chk("t4_no_pulse", 16'(pulses - p0), 16'd0);
    send_frame(8'h1C, 1'b0, 1'b0);
    chk("t4_code", bus.code, 16'h321C);
    chk("t4_error", {15'b0, bus.error}, 16'h0000);

    // 5: short glitches on the clock line
    do_reset();
    p0 = pulses;
    send_frame(8'h1C, 1'b0, 1'b1);
    chk("t5_code", bus.code, 16'h001C);
    chk("t5_error", {15'b0, bus.error}, 16'h0000);
    chk("t5_pulses", 16'(pulses - p0), 16'd1);

    // 6: reset mid-frame, then a good frame
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) send_bit(i[0], 1'b0);
    do_reset();
    p0 = pulses;
    send_frame(8'h45, 1'b0, 1'b0);
    chk("t6_code", bus.code, 16'h0045);
    chk("t6_error", {15'b0, bus.error}, 16'h0000);
    chk("t6_pulses", 16'(pulses - p0), 16'd1);

    chk("sb_drained", 16'(exp_q.size()), 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
